// File: rtl/decim_stream_sequencer.sv
// Run-control and readout sequencer for the CIC decimator: dump/clear generation,
// settling-word discard, word FIFO and MSB-first byte serialiser. Option: SEQ_FRAME_TAG_EN.
`timescale 1ns/1ps

// state   | meaning
// S_IDLE  | waiting for start; cfg_load accepted
// S_PRIME | dumping, discarding comb-settling words
// S_RUN   | dumping, pushing filter words into the FIFO
// S_DRAIN | no dumps/pushes; emptying FIFO and serialiser
module decim_stream_sequencer #(
  parameter int DATA_BITS   = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int DEF_RATIO   = 8,
  parameter int PRIME_WORDS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [7:0]           cfg_ratio,
  input  logic                 cfg_load,
  output logic                 filt_clr,
  output logic                 dump,
  input  logic [DATA_BITS-1:0] filt_data,
  input  logic                 filt_valid,
  output logic [7:0]           out_byte,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic [7:0]           overflow_cnt
);

`ifdef SEQ_FRAME_TAG_EN
  localparam int TAG_BITS = 8;
`else
  localparam int TAG_BITS = 0;
`endif
  localparam int WORD_W = DATA_BITS + TAG_BITS;
  localparam int NBYTES = WORD_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PC_W   = (PRIME_WORDS > 0) ? $clog2(PRIME_WORDS + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [7:0]        ratio_reg;
  logic [7:0]        phase_cnt;
  logic [PC_W-1:0]   prime_cnt;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [IDX_W-1:0]  byte_idx;
  logic [WORD_W-1:0] push_word;

  logic              go, run_phase, at_tc, prime_last;
  logic              push_req, full, push, drop;
  logic              hs, release_w, advance, load;
  logic [WORD_W-1:0] sel_word, shifted;
  logic [IDX_W-1:0]  sel_idx;
  logic [7:0]        byte_d;
  logic              last_d;

  assign busy = (state_q != S_IDLE);

`ifdef SEQ_FRAME_TAG_EN
  logic [7:0] frame_cnt;
  always_ff @(posedge clk) begin
    if (reset) frame_cnt <= '0;
    else if (go) frame_cnt <= '0;
    else if (push) frame_cnt <= frame_cnt + 8'd1;
  end
  assign push_word = {frame_cnt, filt_data};
`else
  assign push_word = filt_data;
`endif

  always_comb begin
    go         = (state_q == S_IDLE) && start && !stop;
    run_phase  = (state_q == S_PRIME) || (state_q == S_RUN);
    at_tc      = (phase_cnt == ratio_reg - 8'd1);
    prime_last = (PRIME_WORDS == 0) ||
                 (filt_valid && (prime_cnt == PC_W'(PRIME_WORDS - 1)));
    push_req   = (state_q == S_RUN) && filt_valid;
    full       = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    push       = push_req && !full;
    drop       = push_req && full;
    // The word being serialised stays in the FIFO until its last byte is taken.
    hs         = out_valid && out_ready;
    release_w  = hs && out_last;
    advance    = hs && !out_last;
    load       = (!out_valid && (fifo_cnt != '0)) ||
                 (release_w && (fifo_cnt > CNT_W'(1)));
    sel_word   = mem[rd_ptr];
    sel_idx    = byte_idx + IDX_W'(1);
    if (load) begin
      sel_idx = '0;
      if (out_valid) sel_word = mem[rd_ptr + PTR_W'(1)];
    end
    shifted    = sel_word << (8 * sel_idx);
    byte_d     = shifted[WORD_W-1 -: 8];
    last_d     = (sel_idx == IDX_W'(NBYTES - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_PRIME;
      S_PRIME: if (stop) state_d = S_DRAIN;
               else if (prime_last) state_d = S_RUN;
      S_RUN:   if (stop) state_d = S_DRAIN;
      S_DRAIN: if ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && release_w))
                 state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ratio_reg    <= 8'(DEF_RATIO);
      phase_cnt    <= '0;
      prime_cnt    <= '0;
      dump         <= 1'b0;
      filt_clr     <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      filt_clr <= go;
      dump     <= run_phase && !stop && at_tc;
      if (state_q == S_IDLE && cfg_load)
        ratio_reg <= (cfg_ratio < 8'd2) ? 8'd2 : cfg_ratio;
      if (go) begin
        phase_cnt    <= '0;
        prime_cnt    <= '0;
        overflow_cnt <= '0;
      end else begin
        if (run_phase) phase_cnt <= at_tc ? 8'd0 : phase_cnt + 8'd1;
        else           phase_cnt <= '0;
        if (state_q == S_PRIME && filt_valid) prime_cnt <= prime_cnt + PC_W'(1);
        if (drop && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + PTR_W'(1);
      if (release_w) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, release_w})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_byte  <= '0;
      out_last  <= 1'b0;
      byte_idx  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_byte  <= byte_d;
      out_last  <= last_d;
      byte_idx  <= '0;
    end else if (advance) begin
      out_byte  <= byte_d;
      out_last  <= last_d;
      byte_idx  <= sel_idx;
    end else if (release_w) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decim_stream_sequencer.sv
// Directed bench for decim_stream_sequencer: table of ratio settings plus
// hand-written sequences for priming, overflow, drain and reset abort.
`timescale 1ns/1ps

module tb_decim_stream_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, cfg_load = 1'b0;
  logic [7:0]  cfg_ratio = 8'd0;
  logic        filt_clr, dump;
  logic [15:0] filt_data = 16'd0;
  logic        filt_valid = 1'b0;
  logic [7:0]  out_byte;
  logic        out_valid, out_last, busy;
  logic        out_ready = 1'b0;
  logic [7:0]  overflow_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] cap_byte [16];
  logic       cap_last [16];
  int         cap_cyc  [16];
  int         cap_n;

  decim_stream_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_ratio(cfg_ratio), .cfg_load(cfg_load), .filt_clr(filt_clr), .dump(dump),
    .filt_data(filt_data), .filt_valid(filt_valid), .out_byte(out_byte),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       do_load;
    logic [7:0] ratio_in;
    int         exp_period;
  } ratio_vec_t;

  ratio_vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load_ratio(input logic [7:0] r);
    cfg_load = 1'b1;
    cfg_ratio = r;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic feed(input logic [15:0] d);
    filt_valid = 1'b1;
    filt_data = d;
    step();
    filt_valid = 1'b0;
  endtask

  task automatic wait_dump(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!dump && n < 600);
  endtask

  task automatic stop_and_idle(input string name);
    int n;
    stop = 1'b1;
    step();
    stop = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic capture(input int ncyc);
    cap_n = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (out_valid && out_ready && cap_n < 16) begin
        cap_byte[cap_n] = out_byte;
        cap_last[cap_n] = out_last;
        cap_cyc[cap_n]  = cyc;
        cap_n++;
      end
      step();
    end
  endtask

  initial begin
    int n;
    int dcount, bcount;
    logic [7:0] exp4 [8];
    logic [7:0] exp5 [4];

    vecs[0] = '{1'b0, 8'd0,   8};
    vecs[1] = '{1'b1, 8'd1,   2};
    vecs[2] = '{1'b1, 8'd0,   2};
    vecs[3] = '{1'b1, 8'd5,   5};
    vecs[4] = '{1'b1, 8'd255, 255};
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    exp5 = '{8'hC0, 8'hC1, 8'hD0, 8'hD1};

    do_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_dump", dump, 1'b0);
    chk("rst_filt_clr", filt_clr, 1'b0);
    chk("rst_overflow", overflow_cnt, 8'd0);
    chk("rst_out_byte", out_byte, 8'd0);

    // Ratio table: period of the first three dumps after start.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].do_load) load_ratio(vecs[v].ratio_in);
      pulse_start();
      chk($sformatf("v%0d_filt_clr", v), filt_clr, 1'b1);
      chk($sformatf("v%0d_busy", v), busy, 1'b1);
      for (int k = 0; k < 3; k++) begin
        wait_dump(n);
        chk($sformatf("v%0d_dump%0d_period", v, k), n, vecs[v].exp_period);
      end
      step();
      chk($sformatf("v%0d_dump_pulse", v), dump, 1'b0);
      stop_and_idle($sformatf("v%0d_idle", v));
    end

    // cfg_load in RUN is ignored.
    load_ratio(8'd1);
    pulse_start();
    feed(16'h0001);
    feed(16'h0002);
    load_ratio(8'd20);
    wait_dump(n);
    wait_dump(n);
    chk("run_load_ignored_a", n, 2);
    wait_dump(n);
    chk("run_load_ignored_b", n, 2);
    stop_and_idle("run_load_idle");

    // Priming discard and basic serialisation.
    do_reset();
    out_ready = 1'b1;
    pulse_start();
    chk("prime_filt_clr_on", filt_clr, 1'b1);
    step();
    chk("prime_filt_clr_off", filt_clr, 1'b0);
    feed(16'h1111);
    step();
    feed(16'h2222);
    feed(16'hABCD);
    capture(6);
    chk("prime_nbytes", cap_n, 2);
    chk("prime_b0", cap_byte[0], 8'hAB);
    chk("prime_l0", cap_last[0], 1'b0);
    chk("prime_b1", cap_byte[1], 8'hCD);
    chk("prime_l1", cap_last[1], 1'b1);
    stop_and_idle("prime_idle");

    // Overflow with sink stalled, then back-to-back drain.
    do_reset();
    out_ready = 1'b0;
    pulse_start();
    feed(16'h0000);
    feed(16'h0000);
    feed(16'h1122);
    feed(16'h3344);
    feed(16'h5566);
    feed(16'h7788);
    feed(16'h99AA);
    feed(16'hBBCC);
    chk("ovf_cnt", overflow_cnt, 8'd2);
    chk("ovf_valid", out_valid, 1'b1);
    step();
    step();
    step();
    chk("ovf_stable_byte", out_byte, 8'h11);
    chk("ovf_stable_last", out_last, 1'b0);
    chk("ovf_stable_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    capture(12);
    chk("ovf_nbytes", cap_n, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_b%0d", i), cap_byte[i], exp4[i]);
      chk($sformatf("ovf_l%0d", i), cap_last[i], (i % 2 == 1));
    end
    chk("ovf_no_bubble", cap_cyc[7] - cap_cyc[0], 7);
    stop_and_idle("ovf_idle");

    // Stop with two words buffered.
    out_ready = 1'b0;
    pulse_start();
    chk("drain_ovf_cleared", overflow_cnt, 8'd0);
    feed(16'h0000);
    feed(16'h0000);
    feed(16'hC0C1);
    feed(16'hD0D1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("drain_busy", busy, 1'b1);
    feed(16'hE0E0);
    dcount = 0;
    bcount = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dump) dcount++;
      if (!busy) bcount++;
    end
    chk("drain_no_dump", dcount, 0);
    chk("drain_busy_held", bcount, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_busy%0d", i), busy, 1'b1);
      chk($sformatf("drain_valid%0d", i), out_valid, 1'b1);
      chk($sformatf("drain_b%0d", i), out_byte, exp5[i]);
      chk($sformatf("drain_l%0d", i), out_last, (i % 2 == 1));
      step();
    end
    chk("drain_idle", busy, 1'b0);
    chk("drain_valid_off", out_valid, 1'b0);
    capture(6);
    chk("drain_no_extra", cap_n, 0);

    // Reset while a byte is stalled.
    out_ready = 1'b0;
    load_ratio(8'd3);
    pulse_start();
    feed(16'h0000);
    feed(16'h0000);
    feed(16'h1234);
    step();
    step();
    chk("abort_pre_valid", out_valid, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_last", out_last, 1'b0);
    chk("abort_dump", dump, 1'b0);
    out_ready = 1'b1;
    pulse_start();
    wait_dump(n);
    chk("abort_ratio_default", n, 8);
    capture(10);
    chk("abort_fifo_empty", cap_n, 0);
    stop_and_idle("abort_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
